// File: rtl/next_pc_predictor_if.sv
// Fetch-side bus between the PC register / EX stage and the next-PC predictor.
// The master drives the fetch PC and the EX-stage resolution; the slave returns the prediction and statistics.
interface next_pc_predictor_if;
    logic        start_i;
    logic        mem_stall_i;
    logic [31:0] fetch_pc_i;
    logic [31:0] next_pc_o;
    logic        pred_taken_o;
    logic        upd_valid_i;
    logic [31:0] upd_pc_i;
    logic [31:0] upd_target_i;
    logic        upd_taken_i;
    logic        upd_mispredict_i;
    logic [31:0] redirect_pc_i;
    logic [31:0] branch_cnt_o;
    logic [31:0] mispredict_cnt_o;

    modport master (
        output start_i, mem_stall_i, fetch_pc_i,
        output upd_valid_i, upd_pc_i, upd_target_i, upd_taken_i,
        output upd_mispredict_i, redirect_pc_i,
        input  next_pc_o, pred_taken_o, branch_cnt_o, mispredict_cnt_o
    );

    modport slave (
        input  start_i, mem_stall_i, fetch_pc_i,
        input  upd_valid_i, upd_pc_i, upd_target_i, upd_taken_i,
        input  upd_mispredict_i, redirect_pc_i,
        output next_pc_o, pred_taken_o, branch_cnt_o, mispredict_cnt_o
    );
endinterface

// File: rtl/next_pc_predictor.sv
// Next-PC selection backed by a direct-mapped BTB with 2-bit saturating counters.
// The EX stage trains the BTB; branch and mispredict totals are kept alongside.
module next_pc_predictor #(
    parameter  int INDEX_BITS = 4,
    localparam int TAG_BITS   = 32 - INDEX_BITS - 2
) (
    input  logic clk_i,
    input  logic rst_i,
    next_pc_predictor_if.slave bus
);
    localparam int ENTRIES = 1 << INDEX_BITS;

    logic [ENTRIES-1:0]                r_valid;
    logic [ENTRIES-1:0][TAG_BITS-1:0]  r_tag;
    logic [ENTRIES-1:0][31:0]          r_target;
    logic [ENTRIES-1:0][1:0]           r_ctr;
    logic [31:0]                       r_branchCnt;
    logic [31:0]                       r_mispredictCnt;

    logic [INDEX_BITS-1:0] w_fetchIdx;
    logic [TAG_BITS-1:0]   w_fetchTag;
    logic                  w_fetchHit;
    logic                  w_predTaken;
    logic [INDEX_BITS-1:0] w_updIdx;
    logic [TAG_BITS-1:0]   w_updTag;
    logic                  w_updHit;
    logic                  w_we;
    logic [3:0]            w_unusedPcBits;

    assign w_fetchIdx     = bus.fetch_pc_i[INDEX_BITS+1:2];
    assign w_fetchTag     = bus.fetch_pc_i[31:INDEX_BITS+2];
    assign w_updIdx       = bus.upd_pc_i[INDEX_BITS+1:2];
    assign w_updTag       = bus.upd_pc_i[31:INDEX_BITS+2];
    assign w_unusedPcBits = {bus.fetch_pc_i[1:0], bus.upd_pc_i[1:0]};

    assign w_fetchHit  = r_valid[w_fetchIdx] && (r_tag[w_fetchIdx] == w_fetchTag);
    assign w_predTaken = w_fetchHit && r_ctr[w_fetchIdx][1];
    assign w_updHit    = r_valid[w_updIdx] && (r_tag[w_updIdx] == w_updTag);
    assign w_we        = bus.upd_valid_i && bus.start_i && !bus.mem_stall_i;

    // A redirect wins over any prediction; it is honoured even without upd_valid_i.
    always_comb begin
        bus.next_pc_o = bus.fetch_pc_i + 32'd4;
        if (bus.upd_mispredict_i) begin
            bus.next_pc_o = bus.redirect_pc_i;
        end else if (w_predTaken) begin
            bus.next_pc_o = r_target[w_fetchIdx];
        end
    end

    assign bus.pred_taken_o     = w_predTaken;
    assign bus.branch_cnt_o     = r_branchCnt;
    assign bus.mispredict_cnt_o = r_mispredictCnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i]  <= 1'b0;
                r_tag[i]    <= '0;
                r_target[i] <= '0;
                r_ctr[i]    <= 2'b01;
            end
        end else if (w_we) begin
            if (w_updHit) begin
                if (bus.upd_taken_i) begin
                    if (r_ctr[w_updIdx] != 2'b11) begin
                        r_ctr[w_updIdx] <= r_ctr[w_updIdx] + 2'd1;
                    end
                    r_target[w_updIdx] <= bus.upd_target_i;
                end else if (r_ctr[w_updIdx] != 2'b00) begin
                    r_ctr[w_updIdx] <= r_ctr[w_updIdx] - 2'd1;
                end
            end else if (bus.upd_taken_i) begin
                // Allocation silently evicts whatever aliased into this slot.
                r_valid[w_updIdx]  <= 1'b1;
                r_tag[w_updIdx]    <= w_updTag;
                r_target[w_updIdx] <= bus.upd_target_i;
                r_ctr[w_updIdx]    <= 2'b10;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_branchCnt     <= '0;
            r_mispredictCnt <= '0;
        end else if (w_we) begin
            r_branchCnt <= r_branchCnt + 32'd1;
            if (bus.upd_mispredict_i) begin
                r_mispredictCnt <= r_mispredictCnt + 32'd1;
            end
        end
    end
endmodule

// File: tb/tb_next_pc_predictor.sv
// Directed bench for next_pc_predictor: hand-computed next-PC, prediction and counter values.
module tb_next_pc_predictor;
    logic clk;
    logic rst;
    int   compareCount;
    int   mismatchCount;

    next_pc_predictor_if bus();

    next_pc_predictor #(.INDEX_BITS(4)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [31:0] pc, input logic [31:0] target,
                                 input logic taken, input logic mispredict, input logic [31:0] redirect);
        bus.upd_valid_i      = valid;
        bus.upd_pc_i         = pc;
        bus.upd_target_i     = target;
        bus.upd_taken_i      = taken;
        bus.upd_mispredict_i = mispredict;
        bus.redirect_pc_i    = redirect;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fetchCheck(input string tag, input logic [31:0] pc, input logic [31:0] expNext, input logic expPred);
        bus.fetch_pc_i = pc;
        #1;
        checkOutput({tag, "_next"}, bus.next_pc_o, expNext);
        checkOutput({tag, "_pred"}, {31'd0, bus.pred_taken_o}, {31'd0, expPred});
    endtask

    initial begin
        compareCount  = 0;
        mismatchCount = 0;
        rst = 1'b1;
        bus.start_i     = 1'b1;
        bus.mem_stall_i = 1'b0;
        bus.fetch_pc_i  = 32'h0;
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset state and sequential fallthrough
        fetchCheck("reset_fetch", 32'h100, 32'h104, 1'b0);
        checkOutput("reset_branch", bus.branch_cnt_o, 32'd0);
        checkOutput("reset_misp", bus.mispredict_cnt_o, 32'd0);

        // Allocate 0x40 -> 0x80; same-cycle lookup still sees the empty entry
        applyStimulus(1'b1, 32'h40, 32'h80, 1'b1, 1'b0, 32'h0);
        fetchCheck("nobypass", 32'h40, 32'h44, 1'b0);
        tick();
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        fetchCheck("alloc_hit", 32'h40, 32'h80, 1'b1);
        checkOutput("alloc_branch", bus.branch_cnt_o, 32'd1);
        fetchCheck("alias_miss", 32'h440, 32'h444, 1'b0);

        // Counter walk: 2 -> 3 -> 3 (saturate) -> 2 -> 1
        applyStimulus(1'b1, 32'h40, 32'h80, 1'b1, 1'b0, 32'h0);
        tick();
        tick();
        applyStimulus(1'b1, 32'h40, 32'h80, 1'b0, 1'b0, 32'h0);
        tick();
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        fetchCheck("walk_ctr2", 32'h40, 32'h80, 1'b1);
        applyStimulus(1'b1, 32'h40, 32'h80, 1'b0, 1'b0, 32'h0);
        tick();
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        fetchCheck("walk_ctr1", 32'h40, 32'h44, 1'b0);
        checkOutput("walk_branch", bus.branch_cnt_o, 32'd5);

        // Back to weakly taken so the redirect has a prediction to override
        applyStimulus(1'b1, 32'h40, 32'h80, 1'b1, 1'b0, 32'h0);
        tick();
        applyStimulus(1'b0, 32'h40, 32'h80, 1'b0, 1'b1, 32'h200);
        fetchCheck("redirect_novalid", 32'h40, 32'h200, 1'b1);
        tick();
        checkOutput("redirect_novalid_misp", bus.mispredict_cnt_o, 32'd0);
        checkOutput("redirect_novalid_branch", bus.branch_cnt_o, 32'd6);
        applyStimulus(1'b1, 32'h84, 32'h0, 1'b0, 1'b1, 32'h300);
        fetchCheck("redirect_valid", 32'h40, 32'h300, 1'b1);
        tick();
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        checkOutput("redirect_valid_misp", bus.mispredict_cnt_o, 32'd1);
        checkOutput("redirect_valid_branch", bus.branch_cnt_o, 32'd7);
        fetchCheck("entry0_kept", 32'h40, 32'h80, 1'b1);

        // Stall holds off training until the one unstalled cycle
        bus.mem_stall_i = 1'b1;
        applyStimulus(1'b1, 32'h108, 32'h300, 1'b1, 1'b0, 32'h0);
        repeat (3) tick();
        checkOutput("stall_branch", bus.branch_cnt_o, 32'd7);
        fetchCheck("stall_notrained", 32'h108, 32'h10C, 1'b0);
        bus.mem_stall_i = 1'b0;
        tick();
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        tick();
        checkOutput("release_branch", bus.branch_cnt_o, 32'd8);
        fetchCheck("release_trained", 32'h108, 32'h300, 1'b1);

        // start_i low blocks training and counting
        bus.start_i = 1'b0;
        applyStimulus(1'b1, 32'h20C, 32'h400, 1'b1, 1'b1, 32'h500);
        tick();
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        bus.start_i = 1'b1;
        checkOutput("nostart_branch", bus.branch_cnt_o, 32'd8);
        checkOutput("nostart_misp", bus.mispredict_cnt_o, 32'd1);
        fetchCheck("nostart_miss", 32'h20C, 32'h210, 1'b0);

        // Fallthrough wraps at the top of the address space
        fetchCheck("wrap", 32'hFFFF_FFFC, 32'h0, 1'b0);

        // Asynchronous reset between clock edges clears everything at once
        #2;
        rst = 1'b1;
        fetchCheck("async_rst_entry0", 32'h40, 32'h44, 1'b0);
        fetchCheck("async_rst_entry2", 32'h108, 32'h10C, 1'b0);
        checkOutput("async_rst_branch", bus.branch_cnt_o, 32'd0);
        checkOutput("async_rst_misp", bus.mispredict_cnt_o, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end
endmodule
